kuznechik_arbiter: RTL and testbench
====================================

KUZNECHIK_ARBITER -- requirements
Module: kuznechik_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles allowed in WAIT before abort (legal range 2..255).
REQ-002 Parameter: TMR_W, default 8, timer width; SHALL satisfy 2**TMR_W > TIMEOUT_CYCLES.
REQ-003 Port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-005 Ports: req0_valid_i / req1_valid_i  in  1  requester N has a block to encrypt.
REQ-006 Ports: req0_ready_o / req1_ready_o  out  1  requester N's block accepted this cycle.
REQ-007 Ports: req0_data_i / req1_data_i  in  128  plaintext from requester N.
REQ-008 Ports: rsp0_valid_o / rsp1_valid_o  out  1  result for requester N available.
REQ-009 Ports: rsp0_ready_i / rsp1_ready_i  in  1  requester N consumes result.
REQ-010 Ports: rsp_data_o  out  128  result block, shared by both response ports.
REQ-011 Ports: rsp_err_o  out  1  result is a timeout abort; qualified by rspN_valid_o.
REQ-012 Ports: core_data_o  out  128, core_request_o  out  1, core_ack_o  out  1, core_resetn_o  out  1  drive cipher core.
REQ-013 Ports: core_data_i  in  128, core_valid_i  in  1, core_busy_i  in  1  from cipher core.
REQ-014 Port: err_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 A transfer occurs when reqN_valid_i and reqN_ready_o are both high in the same cycle.
REQ-017 In IDLE with core_busy_i=0, the block SHALL combinationally raise ready for exactly one valid requester, selected by the round-robin pointer; it SHALL capture that requester's data and owner ID, then enter ISSUE.
REQ-018 When both requesters are valid, the grant goes to the requester not granted last; the pointer resets to requester 0.
REQ-019 In IDLE with core_busy_i=1, both ready outputs SHALL remain 0.
REQ-020 In ISSUE, core_request_o=1 for exactly one cycle with core_data_o=captured data; the block then enters WAIT and clears the timer.
REQ-021 core_data_o SHALL hold the captured data stable from ISSUE until the block leaves WAIT.
REQ-022 In WAIT, the timer increments every cycle.
REQ-023 In WAIT, core_valid_i=1 SHALL capture core_data_i into the result register, pulse core_ack_o for 1 cycle, clear the error flag and enter RESP.
REQ-024 If the timer reaches TIMEOUT_CYCLES-1 without core_valid_i, the block SHALL:
  - pulse err_o and drive core_resetn_o=0 for 1 cycle;
  - zero the result and set the error flag;
  - enter RESP.
REQ-025 If core_valid_i and timeout coincide, core_valid_i wins and no error is raised.
REQ-026 In RESP, only the owner's rspN_valid_o=1; rsp_data_o and rsp_err_o hold stable until that owner's rspN_ready_i=1.
REQ-027 On the owner's handshake, the block returns to IDLE and the pointer moves to the other requester; a new grant is possible from the following cycle.
REQ-028 A response stall SHALL hold RESP indefinitely, with no new grants.
REQ-029 Minimum latency: accept to rsp valid = core latency + 2 cycles.

Reset
REQ-030 While rst_i=1 the block SHALL be in IDLE with all outputs 0 except core_resetn_o=0; data registers, timer, error flag and pointer are cleared.
REQ-031 Reset mid-operation aborts any block in flight, with no response and no err_o; core_resetn_o returns to 1 on the first clock after rst_i falls.

Structure
REQ-032 Package kuznechik_ctrl_pkg SHALL hold the FSM state typedef, the owner ID typedef and the TIMEOUT_CYCLES default constant.
REQ-033 Sub-module rr_arbiter2 SHALL contain the 2-way round-robin grant and pointer; the rest is flat.

Verification
REQ-034 Single block: req0 data 1122334455667700ffeeddccbbaa9988 with a core model returning 7f679d90bebc24305a468d42b9d4edcd after 10 cycles -> rsp0_valid_o at 12 cycles after accept, correct data, rsp_err_o=0, core_ack_o one pulse.
REQ-035 Contention: both requesters valid continuously for 4 blocks -> grants alternate 0,1,0,1 with no double grant.
REQ-036 Timeout: core never raises valid, TIMEOUT_CYCLES=64 -> err_o and core_resetn_o=0 pulses 64 cycles after ISSUE; rsp_err_o=1 with data 0.
REQ-037 Backpressure: rsp1_ready_i low for 20 cycles while req0 is valid -> req0_ready_o stays 0 and rsp_data_o is stable; accept occurs the cycle after the rsp1 handshake.
REQ-038 Reset in WAIT: assert rst_i 3 cycles after ISSUE -> outputs clear asynchronously, no rsp valid, pointer back to 0.

Source files
------------

// File: rtl/kuznechik_ctrl_pkg.sv
// Shared types and constants for the Kuznechik request arbiter.
//   state_t                - arbiter FSM states
//   owner_t                - requester ID (0 or 1)
//   TIMEOUT_CYCLES_DEFAULT - default WAIT budget before a block is aborted
package kuznechik_ctrl_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef logic owner_t;

endpackage

// File: rtl/kuznechik_arbiter_if.sv
// Bundle of requester, response and cipher-core signals around the arbiter.
//   slave  : arbiter side (takes requests, drives responses and the core)
//   master : environment side (requesters, response sinks, cipher core)
interface kuznechik_arbiter_if;

  logic         req0_valid_i;
  logic         req1_valid_i;
  logic         req0_ready_o;
  logic         req1_ready_o;
  logic [127:0] req0_data_i;
  logic [127:0] req1_data_i;
  logic         rsp0_valid_o;
  logic         rsp1_valid_o;
  logic         rsp0_ready_i;
  logic         rsp1_ready_i;
  logic [127:0] rsp_data_o;
  logic         rsp_err_o;
  logic [127:0] core_data_o;
  logic         core_request_o;
  logic         core_ack_o;
  logic         core_resetn_o;
  logic [127:0] core_data_i;
  logic         core_valid_i;
  logic         core_busy_i;
  logic         err_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_data_i, req1_data_i,
    input  rsp0_ready_i, rsp1_ready_i,
    input  core_data_i, core_valid_i, core_busy_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_err_o,
    output core_data_o, core_request_o, core_ack_o, core_resetn_o,
    output err_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_data_i, req1_data_i,
    output rsp0_ready_i, rsp1_ready_i,
    output core_data_i, core_valid_i, core_busy_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_err_o,
    input  core_data_o, core_request_o, core_ack_o, core_resetn_o,
    input  err_o
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> requester 0)
//   valid      : per-requester request
//   enable     : grants allowed this cycle
//   advance    : a block finished; move the pointer away from last_owner
//   last_owner : requester that owned the finished block
//   grant      : one-hot (or zero) grant, combinational
module rr_arbiter2
  import kuznechik_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       advance,
  input  owner_t     last_owner,
  output logic [1:0] grant
);

  // Pointer names the requester that wins a tie.
  owner_t ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ~last_owner;
    end
  end

  always_comb begin
    grant = '0;
    if (enable) begin
      if (valid[ptr_q]) begin
        grant[ptr_q] = 1'b1;
      end else if (valid[~ptr_q]) begin
        grant[~ptr_q] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kuznechik_arbiter.sv
// Shares one Kuznechik cipher core between two requesters.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : requester handshakes, per-requester response valid/ready
//                  with shared rsp_data_o/rsp_err_o, cipher-core drive and
//                  return signals, err_o timeout pulse
// One block is in flight at a time: IDLE grants, ISSUE strobes the core,
// WAIT collects the result or aborts on timeout, RESP holds it for the owner.
module kuznechik_arbiter
  import kuznechik_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned TMR_W          = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  kuznechik_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  owner_t           owner_q;
  logic [127:0]     data_q;
  logic [127:0]     result_q;
  logic [TMR_W-1:0] timer_q;
  logic             err_q;
  logic             resetn_q;
  logic [1:0]       grant;
  logic             grant_en;
  logic             accept;
  logic             rsp_hs;
  logic             timeout;

  // Ready is gated by rst_i so no grant is visible while reset is held.
  assign grant_en = (state_q == ST_IDLE) && !bus.core_busy_i && !rst_i;
  assign accept   = |grant;
  assign rsp_hs   = (state_q == ST_RESP) &&
                    (owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i);
  // A core result in the last WAIT cycle takes priority over the abort.
  assign timeout  = (state_q == ST_WAIT) && !bus.core_valid_i &&
                    (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  rr_arbiter2 u_rr (
    .clk        (clk_i),
    .rst        (rst_i),
    .valid      ({bus.req1_valid_i, bus.req0_valid_i}),
    .enable     (grant_en),
    .advance    (rsp_hs),
    .last_owner (owner_q),
    .grant      (grant)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.core_valid_i || timeout) state_d = ST_RESP;
      ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      resetn_q <= 1'b0;
    end else begin
      resetn_q <= 1'b1;
      if ((state_q == ST_IDLE) && accept) begin
        owner_q <= grant[1];
        data_q  <= grant[1] ? bus.req1_data_i : bus.req0_data_i;
      end
      if (state_q == ST_ISSUE) begin
        timer_q <= '0;
      end
      if (state_q == ST_WAIT) begin
        timer_q <= timer_q + 1'b1;
        if (bus.core_valid_i) begin
          result_q <= bus.core_data_i;
          err_q    <= 1'b0;
        end else if (timeout) begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.req0_ready_o   = grant[0];
  assign bus.req1_ready_o   = grant[1];
  assign bus.rsp0_valid_o   = (state_q == ST_RESP) && !owner_q;
  assign bus.rsp1_valid_o   = (state_q == ST_RESP) && owner_q;
  assign bus.rsp_data_o     = result_q;
  assign bus.rsp_err_o      = (state_q == ST_RESP) && err_q;
  assign bus.core_data_o    = data_q;
  assign bus.core_request_o = (state_q == ST_ISSUE);
  assign bus.core_ack_o     = (state_q == ST_WAIT) && bus.core_valid_i;
  assign bus.core_resetn_o  = resetn_q && !timeout;
  assign bus.err_o          = timeout;

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Directed and randomized bench for kuznechik_arbiter with a latency-
// programmable cipher-core model and a transaction-level reference model.
module tb_kuznechik_arbiter;

  localparam logic [127:0] KAT_PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] KAT_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n_ack = 0;
  int   n_err = 0;
  int   core_lat = 0;   // 0 = core never answers

  kuznechik_arbiter_if bus ();

  kuznechik_arbiter #(.TIMEOUT_CYCLES(64), .TMR_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] x);
    if (x == KAT_PT) return KAT_CT;
    return {x[63:0], x[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_5a5a_f0f0_c3c3_6969;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Returns at the mid-cycle point of the accepting cycle.
  task automatic await_accept(output int owner, output bit ok);
    owner = -1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      mid();
      check("one_hot_ready", 192'(bus.req0_ready_o & bus.req1_ready_o), 192'(0));
      if (bus.req0_ready_o && bus.req0_valid_i) begin owner = 0; ok = 1'b1; return; end
      if (bus.req1_ready_o && bus.req1_valid_i) begin owner = 1; ok = 1'b1; return; end
      nxt();
    end
  endtask

  task automatic await_rsp(input int who, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      mid();
      cycles++;
      if ((who == 0) ? bus.rsp0_valid_o : bus.rsp1_valid_o) begin ok = 1'b1; return; end
      nxt();
    end
  endtask

  task automatic consume(input int who);
    nxt();
    if (who == 0) bus.rsp0_ready_i = 1'b1; else bus.rsp1_ready_i = 1'b1;
    mid();
    nxt();
    bus.rsp0_ready_i = 1'b0;
    bus.rsp1_ready_i = 1'b0;
  endtask

  // Cipher core: answers core_lat cycles after the request cycle.
  initial begin : core_model
    int cnt;
    logic [127:0] pend;
    cnt = 0;
    pend = '0;
    bus.core_valid_i = 1'b0;
    bus.core_data_i = '0;
    forever begin
      nxt();
      bus.core_valid_i = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.core_valid_i = 1'b1;
            bus.core_data_i = core_fn(pend);
          end
        end
        if (bus.core_request_o) begin
          pend = bus.core_data_o;
          cnt = core_lat;
        end
      end
    end
  end

  initial begin : pulse_monitor
    forever begin
      mid();
      if (bus.core_ack_o) n_ack++;
      if (bus.err_o) n_err++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int own, cyc, base, nacc, done, due;
    bit ok, found, inflight, last, m_own, m_tmo, exp_go, exp_own;
    logic [127:0] d1, d2, d3, cap, m_data;
    logic [1:0] exp_rv;

    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.req0_data_i = rnd128();
    bus.req1_data_i = rnd128();
    bus.rsp0_ready_i = 1'b0;
    bus.rsp1_ready_i = 1'b0;
    bus.core_busy_i = 1'b0;

    // Reset state, with both requesters already asking.
    repeat (3) nxt();
    mid();
    check("rst_ctrl", 192'({bus.req0_ready_o, bus.req1_ready_o, bus.rsp0_valid_o, bus.rsp1_valid_o,
                            bus.core_request_o, bus.core_ack_o, bus.err_o, bus.rsp_err_o,
                            bus.core_resetn_o}), 192'(0));
    check("rst_data", 192'({bus.rsp_data_o, bus.core_data_o[63:0]}), 192'(0));
    nxt();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    rst = 1'b0;
    mid();
    check("resetn_before_clock", 192'(bus.core_resetn_o), 192'(0));
    nxt();
    mid();
    check("resetn_after_clock", 192'(bus.core_resetn_o), 192'(1));

    // Single block with known-answer data, core latency 10.
    nxt();
    core_lat = 10;
    bus.req0_data_i = KAT_PT;
    bus.req0_valid_i = 1'b1;
    await_accept(own, ok);
    checki("kat_owner", own, 0);
    nxt();
    bus.req0_valid_i = 1'b0;
    base = n_ack;
    check("kat_issue", 192'({bus.core_request_o, bus.core_data_o}), 192'({1'b1, KAT_PT}));
    await_rsp(0, cyc, ok);
    checki("kat_latency", cyc, 12);
    check("kat_data", 192'({bus.rsp_err_o, bus.rsp1_valid_o, bus.rsp_data_o}), 192'({2'b00, KAT_CT}));
    consume(0);
    mid();
    checki("kat_ack_pulses", n_ack - base, 1);
    check("kat_rsp_drop", 192'(bus.rsp0_valid_o), 192'(0));

    // Timeout abort: core never answers.
    nxt();
    core_lat = 0;
    d1 = rnd128();
    bus.req1_data_i = d1;
    bus.req1_valid_i = 1'b1;
    base = n_err;
    await_accept(own, ok);
    checki("to_owner", own, 1);
    nxt();
    bus.req1_valid_i = 1'b0;
    check("to_issue", 192'(bus.core_request_o), 192'(1));
    cyc = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      mid();
      if (bus.err_o) begin found = 1'b1; break; end
      nxt();
      cyc++;
    end
    checki("to_delay", cyc, 64);
    check("to_pulse", 192'({found, bus.core_resetn_o, bus.core_data_o}), 192'({2'b10, d1}));
    nxt();
    mid();
    check("to_rsp", 192'({bus.rsp1_valid_o, bus.rsp_err_o, bus.err_o, bus.core_resetn_o, bus.rsp_data_o}),
          192'({4'b1101, 128'h0}));
    consume(1);
    mid();
    checki("to_err_pulses", n_err - base, 1);

    // Response backpressure on requester 1 while requester 0 waits.
    nxt();
    core_lat = 3;
    d2 = rnd128();
    bus.req1_data_i = d2;
    bus.req1_valid_i = 1'b1;
    await_accept(own, ok);
    checki("bp_owner", own, 1);
    nxt();
    bus.req1_valid_i = 1'b0;
    await_rsp(1, cyc, ok);
    check("bp_rsp_seen", 192'(ok), 192'(1));
    nxt();
    d3 = rnd128();
    bus.req0_data_i = d3;
    bus.req0_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mid();
      check("bp_hold", 192'({bus.req0_ready_o, bus.rsp1_valid_o, bus.rsp_data_o}),
            192'({2'b01, core_fn(d2)}));
      nxt();
    end
    bus.rsp1_ready_i = 1'b1;
    mid();
    check("bp_hs_cycle", 192'(bus.req0_ready_o), 192'(0));
    nxt();
    bus.rsp1_ready_i = 1'b0;
    mid();
    check("bp_accept_next", 192'({bus.req0_ready_o, bus.rsp1_valid_o}), 192'(2'b10));
    nxt();
    bus.req0_valid_i = 1'b0;
    await_rsp(0, cyc, ok);
    check("bp_data", 192'({ok, bus.rsp_err_o, bus.rsp_data_o}), 192'({2'b10, core_fn(d3)}));
    consume(0);

    // Contention after reset: both always valid, grants must alternate from 0.
    rst = 1'b1;
    mid();
    check("rst_clear", 192'({bus.core_resetn_o, bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o}),
          192'(0));
    nxt();
    rst = 1'b0;
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    bus.req0_data_i = rnd128();
    bus.req1_data_i = rnd128();
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    last = 1'b1;
    for (int b = 0; b < 4; b++) begin
      core_lat = $urandom_range(1, 8);
      await_accept(own, ok);
      checki("cont_owner", own, int'(!last));
      last = own[0];
      cap = (own == 1) ? bus.req1_data_i : bus.req0_data_i;
      nxt();
      if (own == 1) bus.req1_data_i = rnd128(); else bus.req0_data_i = rnd128();
      await_rsp(own, cyc, ok);
      check("cont_data", 192'({ok, bus.rsp_err_o, bus.rsp_data_o}), 192'({2'b10, core_fn(cap)}));
      nxt();
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    bus.rsp0_ready_i = 1'b0;
    bus.rsp1_ready_i = 1'b0;

    // Reset in WAIT: finish one block for requester 0 so the pointer sits on 1.
    core_lat = 2;
    bus.req0_valid_i = 1'b1;
    await_accept(own, ok);
    nxt();
    bus.req0_valid_i = 1'b0;
    await_rsp(0, cyc, ok);
    consume(0);
    core_lat = 0;
    bus.req1_valid_i = 1'b1;
    await_accept(own, ok);
    checki("rw_owner", own, 1);
    nxt();
    bus.req1_valid_i = 1'b0;
    check("rw_issue", 192'(bus.core_request_o), 192'(1));
    nxt();
    nxt();
    nxt();
    mid();
    check("rw_inflight", 192'({bus.core_resetn_o, bus.rsp0_valid_o, bus.rsp1_valid_o}), 192'(3'b100));
    base = n_err;
    rst = 1'b1;
    #1;
    check("rw_async_clear", 192'({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.core_request_o, bus.core_ack_o,
                                  bus.err_o, bus.core_resetn_o, bus.rsp_err_o, bus.core_data_o}), 192'(0));
    nxt();
    nxt();
    rst = 1'b0;
    core_lat = 2;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    await_accept(own, ok);
    checki("rw_ptr_reset", own, 0);
    checki("rw_no_err", n_err - base, 0);
    nxt();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    await_rsp(0, cyc, ok);
    check("rw_rsp_after", 192'({ok, bus.rsp1_valid_o}), 192'(2'b10));
    consume(0);

    // Randomized traffic against a transaction-level model.
    last = 1'b0;
    inflight = 1'b0;
    nacc = 0;
    done = 0;
    due = 0;
    m_own = 1'b0;
    m_tmo = 1'b0;
    m_data = '0;
    for (int c = 0; c < 30000 && done < 40; c++) begin
      nxt();
      bus.req0_valid_i = 1'($urandom_range(0, 1));
      bus.req1_valid_i = 1'($urandom_range(0, 1));
      bus.req0_data_i = rnd128();
      bus.req1_data_i = rnd128();
      bus.core_busy_i = ($urandom_range(0, 3) == 0);
      bus.rsp0_ready_i = 1'($urandom_range(0, 1));
      bus.rsp1_ready_i = 1'($urandom_range(0, 1));
      mid();
      exp_go = !inflight && !bus.core_busy_i && (bus.req0_valid_i || bus.req1_valid_i);
      exp_own = (bus.req0_valid_i && bus.req1_valid_i) ? !last : bus.req1_valid_i;
      check("rnd_ready", 192'({bus.req1_ready_o, bus.req0_ready_o}),
            192'(exp_go ? (exp_own ? 2'b10 : 2'b01) : 2'b00));
      exp_rv = (inflight && c >= due) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_rsp_valid", 192'({bus.rsp1_valid_o, bus.rsp0_valid_o}), 192'(exp_rv));
      check("rnd_err_ack", 192'({bus.err_o, bus.core_ack_o}),
            192'((inflight && c == due - 1) ? (m_tmo ? 2'b10 : 2'b01) : 2'b00));
      if (exp_rv != 2'b00) begin
        check("rnd_rsp_data", 192'({bus.rsp_err_o, bus.rsp_data_o}),
              192'({m_tmo, m_tmo ? 128'h0 : core_fn(m_data)}));
        if (m_own ? bus.rsp1_ready_i : bus.rsp0_ready_i) begin
          inflight = 1'b0;
          done++;
        end
      end
      if (exp_go) begin
        inflight = 1'b1;
        m_own = exp_own;
        last = exp_own;
        m_data = exp_own ? bus.req1_data_i : bus.req0_data_i;
        case (nacc)
          0: core_lat = 64;   // result lands in the same cycle as the timeout
          1: core_lat = 0;
          default: core_lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
        endcase
        m_tmo = (core_lat == 0);
        due = c + (m_tmo ? 66 : core_lat + 2);
        nacc++;
      end
    end
    checki("rnd_done", done, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
